// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator: FSM state encodings and default widths.
package sum_accumulator_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int unsigned ACC_W_DEFAULT = 16;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates blocks of up to N 8-bit samples and presents total/count/overflow
// on a valid/ready port; one bubble cycle separates consecutive blocks.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_overflow
);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic [ACC_W:0]   sum_w;
  logic             accept;

  assign accept = in_valid & in_ready_q;
  assign sum_w  = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_data};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          acc_d   = sum_w[ACC_W-1:0];
          count_d = count_q + 8'd1;
          ovf_d   = ovf_q | sum_w[ACC_W];
        end
        // A flush only closes a block that holds at least one sample.
        if (count_d == 8'(N) || (flush && count_d != 8'd0)) begin
          state_d = S_DONE;
        end else if (count_d != 8'd0) begin
          state_d = S_ACCUM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d != S_DONE);
  end

  // in_ready is registered so it reads 0 while rst is held, with no input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q == S_DONE);
  assign out_sum      = (state_q == S_DONE) ? acc_q   : '0;
  assign out_count    = (state_q == S_DONE) ? count_q : '0;
  assign out_overflow = (state_q == S_DONE) ? ovf_q   : 1'b0;

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the 8-bit adder stage. Takes one 8-bit sum per handshake and accumulates a block of up to N samples into a wider register.
- Emits the block total, sample count and an overflow flag on a valid/ready output port.
- Used to total streams of adder results for display and self-check in lab exercises.

Parameters:
- N, 8, samples per block; legal range 1..255.
- ACC_W, 16, accumulator and out_sum width; legal range 9..32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  8  unsigned sum from the adder stage.
- flush  input  1  close the current block early.
- out_valid  output  1  block result is presented.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_W  block total, unsigned.
- out_count  output  8  number of samples in the block.
- out_overflow  output  1  accumulator wrapped during the block.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state is sampled on the rising clk edge.
- Reset values: state IDLE, acc=0, count=0, ovf=0; in_ready=0 while rst is high; out_valid=0, out_sum=0, out_count=0, out_overflow=0.
- States:
  - IDLE: count==0, in_ready=1.
  - ACCUM: 0<count<N, in_ready=1.
  - DONE: in_ready=0, out_valid=1.
- in_ready and out_valid are decoded from the state only; there is no combinational path from any input.
- Accept = in_valid & in_ready. On accept:
  - acc <= acc + zero-extended in_data, modulo 2^ACC_W.
  - count <= count+1.
  - ovf <= ovf | carry out of bit ACC_W-1 (sticky within the block).
- IDLE -> ACCUM on an accept when the new count < N and flush=0.
- IDLE/ACCUM -> DONE when an accept makes count reach N. With N=1, every accept goes straight to DONE.
- IDLE/ACCUM -> DONE on flush with count>0 after the edge. An accept in the same cycle as flush is included in the block.
- flush in IDLE without an accept is ignored (no empty blocks). flush in DONE is ignored.
- Latency: out_valid rises the cycle after the final accept or flush.
- In DONE, out_sum/out_count/out_overflow show the registered acc/count/ovf and hold stable while out_valid=1 and out_ready=0.
- DONE -> IDLE on out_valid & out_ready; acc, count and ovf clear on that edge. in_ready=1 the following cycle, so there is one bubble cycle per block.
- In IDLE/ACCUM, outputs show out_valid=0 and out_sum/out_count/out_overflow=0.
- in_valid while in_ready=0 is not accepted and has no effect. The upstream stage holds its data.
- rst mid-block or in DONE discards the partial or pending result. Outputs take reset values on the next edge.

Decomposition:
- Shared package holds the state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the default ACC_W constant.
- No sub-module: the accumulate is a single ACC_W-bit add with carry out, inline in this block.

Test Plan:
- N=4; accept 15, 20, 100, 28 back-to-back, out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_sum=163, out_count=4, out_overflow=0; in_ready=1 two cycles after the 4th accept.
- N=8; accept 254, 1, then flush with in_valid=1 and in_data=0 in the same cycle -> out_sum=255, out_count=3.
- ACC_W=9, N=4; accept 255, 255, 255 -> out_sum=253 (765 mod 512), out_overflow=1. Next block of 1, 1, 1, 1 -> out_sum=4, out_overflow=0.
- Backpressure: block completes with out_ready=0 for 5 cycles -> out_valid stays 1 with outputs stable, in_ready=0, and in_valid pulses are not accepted. out_ready=1 -> IDLE on the next edge.
- flush in IDLE with no accept -> out_valid stays 0. N=1 with input 0 -> out_sum=0, out_count=1.
- rst asserted for 1 cycle after 2 accepts (15, 20) -> out_valid=0; a following block of 1, 2, 3, 4 gives out_sum=10, with no residue from the discarded samples.
